uart_frame_loader: RTL and testbench

Sequencing controller between the UART receiver and the image frame buffer. It waits for a two-byte sync header and then writes exactly one frame of pixels into the buffer at incrementing addresses. It aborts on line idle timeout and reports completion, errors and a frame count. It sits in `fpga_top` in place of the free-running `write_addr` counter.

---
 rtl/uart_frame_loader_pkg.sv | 36 +++
 rtl/uart_frame_loader_if.sv | 25 ++
 rtl/uart_frame_loader_idle_timer.sv | 32 +++
 rtl/uart_frame_loader.sv | 163 ++++++++++++++++
 tb/tb_uart_frame_loader.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_frame_loader_pkg.sv
// Shared definitions for the UART frame loader: sync bytes, FSM encoding,
// default frame geometry and the clock constant the idle timeout derives from.
// Optional feature macro: FRAME_CHECKSUM_EN (adds the CHECK state).
package frame_pkg;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    localparam int DEF_IMG_W = 160;
    localparam int DEF_IMG_H = 120;
    localparam int DEF_PIX_W = 3;

    localparam int CLK_HZ          = 50_000_000;
    // 10 ms of line silence inside a frame
    localparam int DEF_TIMEOUT_CYC = CLK_HZ / 100;

    typedef enum logic [2:0] {
        WAIT_S0 = 3'd0,
        WAIT_S1 = 3'd1,
        RECV    = 3'd2,
`ifdef FRAME_CHECKSUM_EN
        CHECK   = 3'd3,
`endif
        DONE    = 3'd4
    } state_t;

    // States in which a frame is in progress and the idle timer runs
    function automatic logic is_busy(input state_t s);
`ifdef FRAME_CHECKSUM_EN
        return (s == WAIT_S1) || (s == RECV) || (s == CHECK);
`else
        return (s == WAIT_S1) || (s == RECV);
`endif
    endfunction

endpackage

// File: rtl/uart_frame_loader_if.sv
// Byte-in / pixel-write-out bundle of the frame loader, plus status outputs.
interface uart_frame_loader_if #(
    parameter int ADDR_W = 15,
    parameter int PIX_W  = 3
) ();
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic              busy;
    logic              frame_done;
    logic              frame_err;
    logic [7:0]        frame_count;

    modport master (
        input  rx_valid, rx_data,
        output mem_we, mem_addr, mem_wdata, busy, frame_done, frame_err, frame_count
    );

    modport slave (
        output rx_valid, rx_data,
        input  mem_we, mem_addr, mem_wdata, busy, frame_done, frame_err, frame_count
    );
endinterface

// File: rtl/uart_frame_loader_idle_timer.sv
// Loadable down-counter: reloads on clear, counts down while run is high,
// and flags expired once it has reached zero.
module idle_timer #(
    parameter int LOAD_VAL = 1000,
    parameter int CNT_W    = $clog2(LOAD_VAL + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: reload has priority, then saturating decrement
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = CNT_W'(LOAD_VAL);
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= CNT_W'(LOAD_VAL);
        else        cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);
endmodule

// File: rtl/uart_frame_loader.sv
// Waits for the A5 5A sync header, then writes one IMG_W*IMG_H frame of
// pixels into the frame buffer; aborts on idle timeout.
// Optional feature macro: FRAME_CHECKSUM_EN (trailing XOR checksum byte).
module uart_frame_loader
    import frame_pkg::*;
#(
    parameter int IMG_W       = DEF_IMG_W,
    parameter int IMG_H       = DEF_IMG_H,
    parameter int ADDR_W      = 15,
    parameter int PIX_W       = DEF_PIX_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input logic               CLOCK_50,
    input logic               rst_n,
    uart_frame_loader_if.master bus
);
    localparam int              N        = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        count_q, count_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif
    logic              timer_expired;

    // Idle timer restarts on every byte and only runs while a frame is open
    idle_timer #(.LOAD_VAL(TIMEOUT_CYC)) u_idle_timer (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .clear   (bus.rx_valid),
        .run     (is_busy(state_q)),
        .expired (timer_expired)
    );

    // Next-state, buffer write and status computation
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = err_q;
        count_d     = count_q;
`ifdef FRAME_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            WAIT_S0: begin
                if (bus.rx_valid && (bus.rx_data == SYNC0)) state_d = WAIT_S1;
            end
            WAIT_S1: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == SYNC1) begin
                        state_d = RECV;
                        idx_d   = '0;
                        err_d   = 1'b0;
`ifdef FRAME_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end else if (bus.rx_data != SYNC0) begin
                        // a repeated A5 keeps us waiting for 5A
                        state_d = WAIT_S0;
                    end
                end
            end
            RECV: begin
                if (bus.rx_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = idx_q;
                    mem_wdata_d = bus.rx_data[PIX_W-1:0];
`ifdef FRAME_CHECKSUM_EN
                    csum_d      = csum_q ^ bus.rx_data;
`endif
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
`ifdef FRAME_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            CHECK: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_S0;
                    end
                end
            end
`endif
            DONE: begin
                done_d  = 1'b1;
                count_d = count_q + 8'd1;
                // a header byte arriving in this cycle must not be lost
                if (bus.rx_valid && (bus.rx_data == SYNC0)) state_d = WAIT_S1;
                else                                        state_d = WAIT_S0;
            end
            default: state_d = WAIT_S0;
        endcase
        // a byte arriving in the expiry cycle takes precedence over the abort
        if (is_busy(state_q) && timer_expired && !bus.rx_valid) begin
            err_d   = 1'b1;
            state_d = WAIT_S0;
            idx_d   = '0;
        end
        busy_d = is_busy(state_d);
    end

    // State and output registers
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_S0;
            idx_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
`ifdef FRAME_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            count_q     <= count_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = done_q;
    assign bus.frame_err   = err_q;
    assign bus.frame_count = count_q;
endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader with a 4x2 frame and a
// 1000-cycle idle timeout. Honours FRAME_CHECKSUM_EN when defined.
module tb_uart_frame_loader;
    import frame_pkg::*;

    localparam int IMG_W = 4, IMG_H = 2, N = IMG_W * IMG_H;
    localparam int ADDR_W = 3, PIX_W = 3, TMO = 1000;

    typedef logic [7:0] frame_t [N];

    logic CLOCK_50 = 1'b0;
    logic rst_n    = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    uart_frame_loader_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

    uart_frame_loader #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .TIMEOUT_CYC(TMO)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int wr_q[$];
    int exp_q[$];
    int done_seen = 0;
    int count_exp = 0;

    // Record every buffer write and every frame_done cycle
    always @(negedge CLOCK_50) begin
        if (bus.mem_we === 1'b1) wr_q.push_back(int'(bus.mem_addr) * 256 + int'(bus.mem_wdata));
        if (bus.frame_done === 1'b1) done_seen++;
    end

    // Bench time is kept at 1 ns after a rising edge between calls
    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge CLOCK_50);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < N; i++) f[i] = 8'($urandom);
        return f;
    endfunction

    // Full good frame: header, pixels, optional checksum; updates the model
    task automatic send_frame(input frame_t px);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        send_byte(SYNC0);
        send_byte(SYNC1);
        for (int i = 0; i < N; i++) begin
            b = px[i];
            exp_q.push_back(i * 256 + int'(b[PIX_W-1:0]));
            x = x ^ b;
            send_byte(b);
        end
`ifdef FRAME_CHECKSUM_EN
        send_byte(x);
`endif
        count_exp = (count_exp + 1) % 256;
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        rst_n = 1'b1;
        idle(2);
        n_cmp++;
        if ({bus.mem_we, bus.busy, bus.frame_done, bus.frame_err} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got we/busy/done/err=%b want 0000",
                     {bus.mem_we, bus.busy, bus.frame_done, bus.frame_err});
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wdata, bus.frame_count} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_values: got addr=%0d data=%0d count=%0d want 0/0/0",
                     bus.mem_addr, bus.mem_wdata, bus.frame_count);
        end
        wr_q.delete();
        done_seen = 0;
        count_exp = 0;
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_seen;
        send_byte(SYNC0);
        send_byte(SYNC1);
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(i * 256 + i);
            send_byte(8'(i));
        end
        n_cmp++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 3'd7, 3'd7}) begin
            n_bad++;
            $display("FAIL basic_last_write: got we=%b addr=%0d data=%0d want we=1 addr=7 data=7",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
`ifdef FRAME_CHECKSUM_EN
        send_byte(8'h00 ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04 ^ 8'h05 ^ 8'h06 ^ 8'h07);
`endif
        count_exp = (count_exp + 1) % 256;
        n_cmp++;
        if (bus.frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_done_early: got %b want 0 at t+1", bus.frame_done);
        end
        idle(1);
        n_cmp++;
        if (bus.frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_done_t2: got %b want 1 at t+2", bus.frame_done);
        end
        idle(2);
        n_cmp++;
        if ({bus.busy, bus.frame_err, bus.frame_count} !== {2'b00, 8'(count_exp)}) begin
            n_bad++;
            $display("FAIL basic_status: got busy=%b err=%b count=%0d want 0/0/%0d",
                     bus.busy, bus.frame_err, bus.frame_count, count_exp);
        end
        n_cmp++;
        if (done_seen - d0 !== 1) begin
            n_bad++;
            $display("FAIL basic_done_pulses: got %0d want 1", done_seen - d0);
        end
        n_cmp++;
        if (wr_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL basic_wr_count: got %0d want %0d", wr_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < wr_q.size(); i++) begin
                n_cmp++;
                if (wr_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL basic_wr[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
                             i, wr_q[i] / 256, wr_q[i] % 256, exp_q[i] / 256, exp_q[i] % 256);
                end
            end
        end
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic test_resync();
        frame_t f;
        int d0;
        for (int i = 0; i < N; i++) f[i] = 8'hFF;
        d0 = done_seen;
        send_byte(SYNC0);
        send_frame(f);
        idle(3);
        n_cmp++;
        if (done_seen - d0 !== 1 || bus.frame_count !== 8'(count_exp)) begin
            n_bad++;
            $display("FAIL resync_done: got pulses=%0d count=%0d want 1/%0d",
                     done_seen - d0, bus.frame_count, count_exp);
        end
        n_cmp++;
        if (wr_q.size() != N) begin
            n_bad++;
            $display("FAIL resync_wr_count: got %0d want %0d", wr_q.size(), N);
        end else begin
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (wr_q[i] !== i * 256 + 7) begin
                    n_bad++;
                    $display("FAIL resync_wr[%0d]: got addr=%0d data=%0d want addr=%0d data=7",
                             i, wr_q[i] / 256, wr_q[i] % 256, i);
                end
            end
        end
        wr_q.delete();
        exp_q.delete();
        // lone 5A, and A5 broken by a non-header byte, must open no frame
        send_byte(8'h00);
        send_byte(SYNC1);
        send_byte(8'h11);
        idle(2);
        send_byte(SYNC0);
        send_byte(8'h00);
        send_byte(SYNC1);
        send_byte(8'h11);
        send_byte(8'h22);
        idle(3);
        n_cmp++;
        if (wr_q.size() != 0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL resync_no_frame: got writes=%0d busy=%b want 0/0", wr_q.size(), bus.busy);
        end
        wr_q.delete();
    endtask

    task automatic test_timeout();
        frame_t f;
        int d0;
        f = rand_frame();
        d0 = done_seen;
        send_byte(SYNC0);
        send_byte(SYNC1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(i * 256 + int'(f[i] & 8'h07));
            send_byte(f[i]);
        end
        idle(900);
        n_cmp++;
        if ({bus.busy, bus.frame_err} !== 2'b10) begin
            n_bad++;
            $display("FAIL timeout_early: got busy=%b err=%b want 1/0 after 900 idle",
                     bus.busy, bus.frame_err);
        end
        idle(150);
        n_cmp++;
        if ({bus.busy, bus.frame_err} !== 2'b01) begin
            n_bad++;
            $display("FAIL timeout_abort: got busy=%b err=%b want 0/1", bus.busy, bus.frame_err);
        end
        n_cmp++;
        if (done_seen - d0 !== 0 || wr_q.size() != 3) begin
            n_bad++;
            $display("FAIL timeout_side: got pulses=%0d writes=%0d want 0/3", done_seen - d0, wr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (wr_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL timeout_wr[%0d]: got %0d want %0d", i, wr_q[i], exp_q[i]);
                end
            end
        end
        wr_q.delete();
        exp_q.delete();
        // next frame clears the error flag at its 5A byte
        send_byte(SYNC0);
        n_cmp++;
        if (bus.frame_err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_err_hold: got %b want 1 before 5A", bus.frame_err);
        end
        send_byte(SYNC1);
        n_cmp++;
        if (bus.frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_err_clear: got %b want 0 after 5A", bus.frame_err);
        end
        idle(2);
        f = rand_frame();
        send_frame(f);
        idle(3);
        n_cmp++;
        if (bus.frame_count !== 8'(count_exp) || wr_q.size() != N) begin
            n_bad++;
            $display("FAIL timeout_recover: got count=%0d writes=%0d want %0d/%0d",
                     bus.frame_count, wr_q.size(), count_exp, N);
        end
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        frame_t f;
        f = rand_frame();
        send_byte(SYNC0);
        send_byte(SYNC1);
        for (int i = 0; i < 4; i++) send_byte(f[i]);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.mem_we, bus.busy, bus.frame_done, bus.frame_err, bus.mem_addr, bus.mem_wdata,
             bus.frame_count} !== 18'd0) begin
            n_bad++;
            $display("FAIL midreset_values: got we=%b busy=%b done=%b err=%b addr=%0d data=%0d count=%0d want all 0",
                     bus.mem_we, bus.busy, bus.frame_done, bus.frame_err, bus.mem_addr,
                     bus.mem_wdata, bus.frame_count);
        end
        @(posedge CLOCK_50);
        #1;
        rst_n = 1'b1;
        idle(1);
        wr_q.delete();
        exp_q.delete();
        count_exp = 0;
        f = rand_frame();
        send_frame(f);
        idle(3);
        n_cmp++;
        if (bus.frame_count !== 8'(count_exp)) begin
            n_bad++;
            $display("FAIL midreset_count: got %0d want %0d", bus.frame_count, count_exp);
        end
        n_cmp++;
        if (wr_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL midreset_wr_count: got %0d want %0d", wr_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < wr_q.size(); i++) begin
                n_cmp++;
                if (wr_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL midreset_wr[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
                             i, wr_q[i] / 256, wr_q[i] % 256, exp_q[i] / 256, exp_q[i] % 256);
                end
            end
        end
        wr_q.delete();
        exp_q.delete();
    endtask

`ifdef FRAME_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] px [N];
        int d0;
        px = '{8'hAA, 8'h55, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
        for (int pass = 0; pass < 2; pass++) begin
            d0 = done_seen;
            send_byte(SYNC0);
            send_byte(SYNC1);
            for (int i = 0; i < N; i++) send_byte(px[i]);
            send_byte(pass == 0 ? 8'h04 : 8'h05);
            if (pass == 0) count_exp = (count_exp + 1) % 256;
            idle(3);
            n_cmp++;
            if (done_seen - d0 !== 1 - pass || bus.frame_err !== 1'(pass)
                || bus.frame_count !== 8'(count_exp)) begin
                n_bad++;
                $display("FAIL checksum_pass%0d: got pulses=%0d err=%b count=%0d want %0d/%0d/%0d",
                         pass, done_seen - d0, bus.frame_err, bus.frame_count, 1 - pass, pass, count_exp);
            end
        end
        wr_q.delete();
    endtask
`endif

    task automatic test_back_to_back();
        int d0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        count_exp = 0;
        idle(1);
        wr_q.delete();
        exp_q.delete();
        d0 = done_seen;
        // frames are streamed with no gap between any two bytes
        for (int k = 0; k < 256; k++) send_frame(rand_frame());
        idle(4);
        n_cmp++;
        if (bus.frame_count !== 8'(count_exp) || count_exp != 0) begin
            n_bad++;
            $display("FAIL b2b_count_wrap: got %0d want %0d", bus.frame_count, count_exp);
        end
        n_cmp++;
        if (done_seen - d0 !== 256) begin
            n_bad++;
            $display("FAIL b2b_done_pulses: got %0d want 256", done_seen - d0);
        end
        n_cmp++;
        if (wr_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL b2b_wr_count: got %0d want %0d", wr_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < wr_q.size(); i++) begin
                n_cmp++;
                if (wr_q[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL b2b_wr[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
                             i, wr_q[i] / 256, wr_q[i] % 256, exp_q[i] / 256, exp_q[i] % 256);
                end
            end
        end
        wr_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resync();
        test_timeout();
        test_reset_mid();
`ifdef FRAME_CHECKSUM_EN
        test_checksum();
`endif
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
